// File: rtl/priv_trap_sequencer.sv
// Trap entry / xRET sequencer: arbitrates the CSR write path,
// waits for drain, then pulses commit and issues a PC redirect.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   trap_req/to_s/is_int/cause   pending trap and its attributes
//   mret, sret          xRET in the retiring stage
//   pipe_clear, ex_mem_stall     drain condition
//   csr_req / csr_grant CSR instruction write-path handshake
//   mtvec/stvec/mepc/sepc        CSR values for target computation
//   trap_commit, xret_commit     one-cycle CSR update pulses
//   insert_pc, priv_pc  one-cycle redirect strobe and target
//   busy, drain_stuck   sequence active, sticky drain timeout
module priv_trap_sequencer #(
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        trap_req,
  input  logic        trap_to_s,
  input  logic        trap_is_int,
  input  logic [4:0]  trap_cause,
  input  logic        mret,
  input  logic        sret,
  input  logic        pipe_clear,
  input  logic        ex_mem_stall,
  input  logic        csr_req,
  input  logic [31:0] mtvec,
  input  logic [31:0] stvec,
  input  logic [31:0] mepc,
  input  logic [31:0] sepc,
  output logic        csr_grant,
  output logic        trap_commit,
  output logic        xret_commit,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        busy,
  output logic        drain_stuck
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_TRAP = 2'd0,
    K_MRET = 2'd1,
    K_SRET = 2'd2
  } kind_t;

  localparam logic [7:0] TIMEOUT = 8'(DRAIN_TIMEOUT);

  state_t      state_q;
  state_t      state_d;
  kind_t       kind_q;
  logic        to_s_q;
  logic        is_int_q;
  logic [4:0]  cause_q;
  logic [31:0] target_q;
  logic [31:0] pc_q;
  logic [7:0]  cnt_q;
  logic        stuck_q;

  logic        any_req;
  logic        drained;
  logic        withdraw;
  logic [7:0]  cnt_inc;
  logic [31:0] tvec;
  logic [31:0] base;
  logic [31:0] vec_off;
  logic [31:0] target_d;

  assign any_req  = trap_req | mret | sret;
  assign drained  = pipe_clear & ~ex_mem_stall;
  // Only a pending interrupt may disappear while draining.
  assign withdraw = (kind_q == K_TRAP) & is_int_q
                  & ~trap_req;
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q
                                     : cnt_q + 8'd1;

  always_comb begin
    tvec    = to_s_q ? stvec : mtvec;
    base    = {tvec[31:2], 2'b00};
    vec_off = {25'd0, cause_q, 2'b00};
    unique case (kind_q)
      K_MRET:  target_d = {mepc[31:2], 2'b00};
      K_SRET:  target_d = {sepc[31:2], 2'b00};
      default: begin
        // Reserved modes 2'b10/2'b11 fall back to direct.
        if ((tvec[1:0] == 2'b01) && is_int_q)
          target_d = base + vec_off;
        else
          target_d = base;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (withdraw)     state_d = IDLE;
        else if (drained) state_d = COMMIT;
      end
      COMMIT:   state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      kind_q   <= K_TRAP;
      to_s_q   <= 1'b0;
      is_int_q <= 1'b0;
      cause_q  <= 5'd0;
      target_q <= 32'd0;
      pc_q     <= 32'd0;
      cnt_q    <= 8'd0;
      stuck_q  <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (trap_req) begin
          kind_q   <= K_TRAP;
          to_s_q   <= trap_to_s;
          is_int_q <= trap_is_int;
          cause_q  <= trap_cause;
        end else if (mret) begin
          kind_q <= K_MRET;
        end else if (sret) begin
          kind_q <= K_SRET;
        end
        if (any_req) cnt_q <= 8'd0;
      end
      if (state_q == DRAIN) begin
        cnt_q <= cnt_inc;
        if (cnt_inc == TIMEOUT) stuck_q <= 1'b1;
        if (drained) target_q <= target_d;
      end
      if (state_q == COMMIT) pc_q <= target_q;
    end
  end

  always_comb begin
    csr_grant   = 1'b0;
    trap_commit = 1'b0;
    xret_commit = 1'b0;
    insert_pc   = 1'b0;
    busy        = (state_q != IDLE);
    unique case (state_q)
      IDLE:     csr_grant = csr_req & ~any_req;
      DRAIN:    ;
      COMMIT: begin
        trap_commit = (kind_q == K_TRAP);
        xret_commit = (kind_q != K_TRAP);
      end
      REDIRECT: insert_pc = 1'b1;
    endcase
  end

  assign priv_pc     = pc_q;
  assign drain_stuck = stuck_q;

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// Self-checking bench for priv_trap_sequencer: target table,
// directed corner sequences and randomized model comparison.
module tb_priv_trap_sequencer;

  localparam int T = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        trap_req, trap_to_s, trap_is_int;
  logic [4:0]  trap_cause;
  logic        mret, sret, pipe_clear, ex_mem_stall;
  logic        csr_req;
  logic [31:0] mtvec, stvec, mepc, sepc;
  logic        csr_grant, trap_commit, xret_commit;
  logic        insert_pc, busy, drain_stuck;
  logic [31:0] priv_pc;

  priv_trap_sequencer #(.DRAIN_TIMEOUT(T)) dut (
    .CLK(CLK), .RST(RST),
    .trap_req(trap_req), .trap_to_s(trap_to_s),
    .trap_is_int(trap_is_int), .trap_cause(trap_cause),
    .mret(mret), .sret(sret),
    .pipe_clear(pipe_clear), .ex_mem_stall(ex_mem_stall),
    .csr_req(csr_req),
    .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
    .csr_grant(csr_grant), .trap_commit(trap_commit),
    .xret_commit(xret_commit), .insert_pc(insert_pc),
    .priv_pc(priv_pc), .busy(busy),
    .drain_stuck(drain_stuck)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Reference model: a request opens a transaction; once the
  // drain condition holds at cycle c, commit is due at c+1 and
  // redirect at c+2. Kind: 0 trap, 1 mret, 2 sret.
  bit          mdl_on = 0;
  int          cyc = 0;
  bit          m_busy, m_wait, m_stuck;
  int          m_kind, m_cnt, m_commit_at, m_redir_at;
  bit          m_to_s, m_int;
  int          m_cause;
  logic [31:0] m_target, m_pc;

  function automatic logic [31:0] ref_target(
    input int k, input bit s, input bit i, input int c);
    logic [31:0] tv;
    logic [31:0] r;
    if (k == 1) return mepc & ~32'h3;
    if (k == 2) return sepc & ~32'h3;
    tv = s ? stvec : mtvec;
    r = tv & ~32'h3;
    if ((tv % 4) == 1 && i) r = r + 32'(c * 4);
    return r;
  endfunction

  task automatic mdl_reset();
    m_busy = 0; m_wait = 0; m_stuck = 0;
    m_kind = 0; m_cnt = 0;
    m_commit_at = -1; m_redir_at = -1;
    m_to_s = 0; m_int = 0; m_cause = 0;
    m_target = 0; m_pc = 0;
  endtask

  task automatic mdl_compare();
    bit g, c;
    g = !m_busy && csr_req && !trap_req && !mret && !sret;
    c = m_busy && !m_wait && cyc == m_commit_at;
    chk("csr_grant", 32'(csr_grant), 32'(g));
    chk("trap_commit", 32'(trap_commit),
        32'(c && m_kind == 0));
    chk("xret_commit", 32'(xret_commit),
        32'(c && m_kind != 0));
    chk("insert_pc", 32'(insert_pc),
        32'(m_busy && cyc == m_redir_at));
    chk("priv_pc", priv_pc, m_pc);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("drain_stuck", 32'(drain_stuck), 32'(m_stuck));
  endtask

  task automatic mdl_step();
    if (RST) begin
      mdl_reset();
    end else if (!m_busy) begin
      if (trap_req || mret || sret) begin
        m_busy = 1; m_wait = 1; m_cnt = 0;
        if (trap_req) begin
          m_kind = 0; m_to_s = trap_to_s;
          m_int = trap_is_int; m_cause = int'(trap_cause);
        end else begin
          m_kind = mret ? 1 : 2;
        end
      end
    end else if (m_wait) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt == T) m_stuck = 1;
      if (m_kind == 0 && m_int && !trap_req) begin
        m_busy = 0; m_wait = 0;
      end else if (pipe_clear && !ex_mem_stall) begin
        m_target = ref_target(m_kind, m_to_s, m_int, m_cause);
        m_wait = 0;
        m_commit_at = cyc + 1;
        m_redir_at = cyc + 2;
      end
    end else if (cyc == m_commit_at) begin
      m_pc = m_target;
    end else if (cyc == m_redir_at) begin
      m_busy = 0;
    end
  endtask

  task automatic tick();
    #1;
    if (mdl_on) mdl_compare();
    mdl_step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    trap_req = 0; trap_to_s = 0; trap_is_int = 0;
    trap_cause = 0; mret = 0; sret = 0;
    pipe_clear = 1; ex_mem_stall = 0; csr_req = 0;
  endtask

  typedef struct {
    int          kind;
    bit          to_s;
    bit          is_int;
    logic [4:0]  cause;
    logic [31:0] tvec;
    logic [31:0] epc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("vec%0d", idx);
    idle_inputs();
    trap_req = (v.kind == 0);
    mret = (v.kind == 1);
    sret = (v.kind == 2);
    trap_to_s = v.to_s;
    trap_is_int = v.is_int;
    trap_cause = v.cause;
    mtvec = v.to_s ? 32'hDEAD_BEE1 : v.tvec;
    stvec = v.to_s ? v.tvec : 32'h0BAD_F001;
    mepc = (v.kind == 1) ? v.epc : 32'h5555_5556;
    sepc = (v.kind == 2) ? v.epc : 32'hAAAA_AAA8;
    #1 chk({s, " busy N"}, 32'(busy), 0);
    tick();
    mret = 0; sret = 0;
    #1 chk({s, " busy N+1"}, 32'(busy), 1);
    chk({s, " tc N+1"}, 32'(trap_commit), 0);
    tick();
    #1 chk({s, " tc N+2"}, 32'(trap_commit),
           32'(v.kind == 0));
    chk({s, " xc N+2"}, 32'(xret_commit),
        32'(v.kind != 0));
    chk({s, " ins N+2"}, 32'(insert_pc), 0);
    tick();
    trap_req = 0;
    #1 chk({s, " ins N+3"}, 32'(insert_pc), 1);
    chk({s, " tc N+3"}, 32'(trap_commit), 0);
    chk({s, " pc N+3"}, priv_pc, v.exp_pc);
    tick();
    #1 chk({s, " busy N+4"}, 32'(busy), 0);
    chk({s, " pc hold"}, priv_pc, v.exp_pc);
    chk({s, " stuck"}, 32'(drain_stuck), 0);
    tick();
  endtask

  initial begin
    vecs[0] = '{0, 0, 1, 5'd7,  32'h0000_1001, 0,
                32'h0000_101C};
    vecs[1] = '{0, 1, 0, 5'd2,  32'h8000_0201, 0,
                32'h8000_0200};
    vecs[2] = '{0, 1, 1, 5'd5,  32'h8000_0203, 0,
                32'h8000_0200};
    vecs[3] = '{0, 0, 1, 5'd3,  32'h0000_2002, 0,
                32'h0000_2000};
    vecs[4] = '{0, 0, 0, 5'd9,  32'h0000_3001, 0,
                32'h0000_3000};
    vecs[5] = '{1, 0, 0, 5'd0,  0, 32'h0000_4002,
                32'h0000_4000};
    vecs[6] = '{2, 0, 0, 5'd0,  0, 32'h1234_5677,
                32'h1234_5674};
    vecs[7] = '{0, 1, 1, 5'd1,  32'h0000_0101, 0,
                32'h0000_0104};

    idle_inputs();
    mtvec = 0; stvec = 0; mepc = 0; sepc = 0;
    RST = 1;
    tick();
    mdl_on = 1;
    tick();
    RST = 0;
    #1 chk("rst busy", 32'(busy), 0);
    chk("rst pc", priv_pc, 0);
    chk("rst stuck", 32'(drain_stuck), 0);
    chk("rst tc", 32'(trap_commit), 0);
    chk("rst ins", 32'(insert_pc), 0);
    csr_req = 1;
    #1 chk("rst grant", 32'(csr_grant), 1);
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Vectored wrap with a five-cycle drain wait.
    idle_inputs();
    mtvec = 32'hFFFF_FFFD;
    trap_req = 1; trap_is_int = 1; trap_cause = 5'd31;
    pipe_clear = 0;
    tick();
    for (int k = 1; k <= 7; k++) begin
      pipe_clear = (k >= 6);
      #1;
      if (k == 3) chk("stuck N+3", 32'(drain_stuck), 0);
      if (k == 4) chk("stuck N+4", 32'(drain_stuck), 1);
      if (k <= 6) chk("wrap no ins", 32'(insert_pc), 0);
      if (k == 7) chk("wrap tc N+7", 32'(trap_commit), 1);
      tick();
    end
    trap_req = 0;
    #1 chk("wrap ins N+8", 32'(insert_pc), 1);
    chk("wrap pc", priv_pc, 32'h0000_0078);
    tick();
    #1 chk("stuck sticky", 32'(drain_stuck), 1);
    tick();

    // CSR vs MRET arbitration.
    idle_inputs();
    csr_req = 1; mret = 1; mepc = 32'h0000_4002;
    #1 chk("arb grant N", 32'(csr_grant), 0);
    tick();
    mret = 0;
    #1 chk("arb grant N+1", 32'(csr_grant), 0);
    tick();
    #1 chk("arb xc N+2", 32'(xret_commit), 1);
    chk("arb grant N+2", 32'(csr_grant), 0);
    tick();
    #1 chk("arb pc N+3", priv_pc, 32'h0000_4000);
    chk("arb grant N+3", 32'(csr_grant), 0);
    tick();
    #1 chk("arb grant N+4", 32'(csr_grant), 1);
    tick();

    // Interrupt withdrawn while draining.
    idle_inputs();
    trap_req = 1; trap_is_int = 1; pipe_clear = 0;
    tick();
    trap_req = 0;
    #1 chk("wd busy N+1", 32'(busy), 1);
    tick();
    pipe_clear = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("wd busy", 32'(busy), 0);
      chk("wd tc", 32'(trap_commit), 0);
      chk("wd ins", 32'(insert_pc), 0);
      tick();
    end

    // Reset during COMMIT.
    idle_inputs();
    mtvec = 32'h0000_5000;
    trap_req = 1;
    tick();
    tick();
    #1 chk("rc tc", 32'(trap_commit), 1);
    RST = 1;
    tick();
    trap_req = 0;
    #1 chk("rc busy", 32'(busy), 0);
    chk("rc ins", 32'(insert_pc), 0);
    chk("rc pc", priv_pc, 0);
    chk("rc stuck", 32'(drain_stuck), 0);
    chk("rc grant", 32'(csr_grant), 0);
    tick();
    RST = 0;
    #1 chk("rc no ins", 32'(insert_pc), 0);
    tick();

    // Randomized run against the model.
    for (int k = 0; k < 3000; k++) begin
      RST = ($urandom_range(0, 199) == 0);
      trap_req = ($urandom_range(0, 5) == 0);
      trap_to_s = 1'($urandom);
      trap_is_int = 1'($urandom);
      trap_cause = 5'($urandom);
      mret = ($urandom_range(0, 9) == 0);
      sret = ($urandom_range(0, 9) == 0);
      pipe_clear = ($urandom_range(0, 2) != 0);
      ex_mem_stall = ($urandom_range(0, 3) == 0);
      csr_req = 1'($urandom);
      mtvec = $urandom;
      stvec = $urandom;
      mepc = $urandom;
      sepc = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
